// File: rtl/avalon_mem_if_responder.sv
// Avalon-MM burst responder backed by an internal word-addressed RAM.
// Serves one burst at a time with a fixed read latency and a sticky protocol-error flag.
module avalon_mem_if_responder #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned BURST_CNT_WIDTH = 4,
    parameter int unsigned READ_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       waitrequest,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       readdatavalid,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic                       read,
    input  logic                       write,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    output logic                       protocol_err
);

    localparam int unsigned BeWidth = DATA_WIDTH / 8;
    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst} state_e;

    state_e                     state_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [BURST_CNT_WIDTH-1:0] beats_q;
    logic [BURST_CNT_WIDTH-1:0] ret_q;
    logic                       wait_q;
    logic                       err_q;

    logic [DATA_WIDTH-1:0]      mem [Depth];
    logic                       rd_vld_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]      rd_dat_q [READ_LATENCY];

    logic                       idle_acc;
    logic                       wr_first;
    logic                       rd_first;
    logic                       wr_beat;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_waddr;
    logic                       rd_issue;
    logic                       pipe_out;
    logic                       len_zero;
    logic [BURST_CNT_WIDTH-1:0] first_len;

    always_comb begin
        idle_acc  = (state_q == StIdle) && !wait_q;
        wr_first  = idle_acc && write;
        // A simultaneous read and write in idle performs the write only.
        rd_first  = idle_acc && read && !write;
        wr_beat   = (state_q == StWrBurst) && write;
        mem_we    = wr_first || wr_beat;
        mem_waddr = wr_first ? address : addr_q;
        rd_issue  = (state_q == StRdBurst) && (beats_q != '0);
        pipe_out  = rd_vld_q[READ_LATENCY-1];
        len_zero  = (burstcount == '0);
        first_len = len_zero ? BURST_CNT_WIDTH'(1) : burstcount;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beats_q <= '0;
            ret_q   <= '0;
            wait_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wait_q <= 1'b0;
                    if (wr_first) begin
                        addr_q  <= address + 1'b1;
                        beats_q <= first_len - 1'b1;
                        if (first_len != BURST_CNT_WIDTH'(1)) begin
                            state_q <= StWrBurst;
                        end
                        if (read || len_zero) begin
                            err_q <= 1'b1;
                        end
                    end else if (rd_first) begin
                        addr_q  <= address;
                        beats_q <= first_len;
                        ret_q   <= first_len;
                        wait_q  <= 1'b1;
                        state_q <= StRdBurst;
                        if (len_zero) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StWrBurst: begin
                    if (read) begin
                        err_q <= 1'b1;
                    end
                    if (write) begin
                        addr_q  <= addr_q + 1'b1;
                        beats_q <= beats_q - 1'b1;
                        if (beats_q == BURST_CNT_WIDTH'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StRdBurst: begin
                    if (rd_issue) begin
                        addr_q  <= addr_q + 1'b1;
                        beats_q <= beats_q - 1'b1;
                    end
                    // Leave once the final beat is on the bus this cycle.
                    if (pipe_out) begin
                        ret_q <= ret_q - 1'b1;
                        if (ret_q == BURST_CNT_WIDTH'(1)) begin
                            state_q <= StIdle;
                            wait_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The RAM read register is stage 0; the last stage only moves on valid so readdata holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                rd_vld_q[k] <= 1'b0;
                rd_dat_q[k] <= '0;
            end
        end else begin
            rd_vld_q[0] <= rd_issue;
            if (rd_issue) begin
                rd_dat_q[0] <= mem[addr_q];
            end
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                rd_vld_q[k] <= rd_vld_q[k-1];
                if (rd_vld_q[k-1]) begin
                    rd_dat_q[k] <= rd_dat_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < BeWidth; b++) begin
            if (mem_we && byteenable[b]) begin
                mem[mem_waddr][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    assign waitrequest   = wait_q;
    assign readdatavalid = rd_vld_q[READ_LATENCY-1];
    assign readdata      = rd_dat_q[READ_LATENCY-1];
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_avalon_mem_if_responder.sv
// Scoreboard bench for avalon_mem_if_responder: random and directed bursts checked
// against a plain array model of the RAM with spec-derived return timing.
module tb_avalon_mem_if_responder;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [9:0]  address;
    logic [3:0]  burstcount;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        protocol_err;

    avalon_mem_if_responder #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .BURST_CNT_WIDTH(4),
        .READ_LATENCY   (L)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .address      (address),
        .burstcount   (burstcount),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model[1024];
    logic [31:0] wbuf[8];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every readdatavalid must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rdv_unexpected", 64'(readdatavalid), 64'(1'b0));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 64'(readdata), 64'(e.data));
                    check("rd_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("rdv_missing", 64'(readdatavalid), 64'(1'b1));
                exp_q.delete(0);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (waitrequest !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) check("wait_ready_timeout", 64'(waitrequest), 64'(1'b0));
    endtask

    task automatic wr_burst(input logic [9:0] addr, input logic [3:0] bc, input int gap,
                            input logic [3:0] be, input bit also_read);
        int          n;
        logic [9:0]  a;
        n = (bc == 0) ? 1 : int'(bc);
        wait_ready();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    write      = 1'b0;
                    address    = 10'($urandom);
                    burstcount = 4'($urandom);
                    @(negedge clk);
                end
            end
            write      = 1'b1;
            read       = (i == 0) ? also_read : 1'b0;
            address    = (i == 0) ? addr : 10'($urandom);
            burstcount = (i == 0) ? bc : 4'($urandom);
            writedata  = wbuf[i];
            byteenable = be;
            @(negedge clk);
            a = addr + 10'(i);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a][8*b +: 8] = wbuf[i][8*b +: 8];
            end
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] addr, input int n, input int t);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = model[addr + 10'(i)];
            e.cyc  = t + L + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic rd_burst(input logic [9:0] addr, input logic [3:0] bc);
        int n;
        int t;
        int k;
        n = (bc == 0) ? 1 : int'(bc);
        wait_ready();
        read       = 1'b1;
        address    = addr;
        burstcount = bc;
        t = cyc + 1;
        push_exp(addr, n, t);
        @(negedge clk);
        read    = 1'b0;
        address = 10'($urandom);
        check("rd_wait_hi", 64'(waitrequest), 64'(1'b1));
        k = 0;
        while (waitrequest === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rd_wait_fall", 64'(cyc), 64'(t + L + n));
    endtask

    task automatic rd_reset_mid(input logic [9:0] addr);
        int t;
        int k;
        wait_ready();
        read       = 1'b1;
        address    = addr;
        burstcount = 4'd8;
        t = cyc + 1;
        push_exp(addr, 8, t);
        @(negedge clk);
        read = 1'b0;
        k = 0;
        while (cyc < t + L + 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_rdv_drop", 64'(readdatavalid), 64'(1'b0));
        check("rst_wait_hi", 64'(waitrequest), 64'(1'b1));
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_burst(addr, 4'd8);
    endtask

    initial begin
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        burstcount = '0;
        writedata  = '0;
        byteenable = '0;
        repeat (5) @(negedge clk);
        check("rst_wait", 64'(waitrequest), 64'(1'b1));
        check("rst_rdv", 64'(readdatavalid), 64'(1'b0));
        check("rst_rdata", 64'(readdata), 64'(0));
        check("rst_err", 64'(protocol_err), 64'(1'b0));
        reset_n = 1'b1;
        #1;
        check("wait_before_edge", 64'(waitrequest), 64'(1'b1));
        @(negedge clk);
        check("wait_after_edge", 64'(waitrequest), 64'(1'b0));

        // Fill the whole RAM so every later read has a known expectation.
        for (int base = 0; base < 1024; base += 8) begin
            for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
            wr_burst(10'(base), 4'd8, 0, 4'hF, 1'b0);
        end
        check("err_after_fill", 64'(protocol_err), 64'(1'b0));

        // Wrapping write/read burst across the top of the RAM.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        wr_burst(10'h3FE, 4'd4, 0, 4'hF, 1'b0);
        rd_burst(10'h3FE, 4'd4);

        // Byte enables.
        wbuf[0] = 32'hFFFF_FFFF;
        wr_burst(10'd5, 4'd1, 0, 4'hF, 1'b0);
        wbuf[0] = 32'h1234_5678;
        wr_burst(10'd5, 4'd1, 0, 4'b0101, 1'b0);
        rd_burst(10'd5, 4'd1);

        // Gapped write with junk address, then an immediate read.
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        wr_burst(10'h100, 4'd3, 2, 4'hF, 1'b0);
        check("gap_idle_wait", 64'(waitrequest), 64'(1'b0));
        rd_burst(10'h100, 4'd3);

        repeat (60) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
                wr_burst(10'($urandom), 4'($urandom_range(1, 8)), $urandom_range(0, 2),
                         4'($urandom), 1'b0);
            end else begin
                rd_burst(10'($urandom), 4'($urandom_range(1, 8)));
            end
        end
        check("err_clean", 64'(protocol_err), 64'(1'b0));

        // Read and write together in idle: write wins, read dropped, error sticks.
        wbuf[0] = $urandom;
        wr_burst(10'h020, 4'd1, 0, 4'hF, 1'b1);
        check("rw_err", 64'(protocol_err), 64'(1'b1));
        repeat (6) @(negedge clk);
        check("rw_no_wait", 64'(waitrequest), 64'(1'b0));
        rd_burst(10'h020, 4'd1);
        check("rw_err_sticky", 64'(protocol_err), 64'(1'b1));

        rd_reset_mid(10'h2C0);
        check("err_cleared", 64'(protocol_err), 64'(1'b0));

        // Zero burstcount acts as a single beat and flags an error.
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        wr_burst(10'h030, 4'd0, 0, 4'hF, 1'b0);
        check("bc0_err", 64'(protocol_err), 64'(1'b1));
        rd_burst(10'h030, 4'd0);
        rd_burst(10'h030, 4'd2);

        repeat (10) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
